// File: rtl/johnson_decoder_if.sv
// johnson_decoder_if: sample input and decoded/status outputs of johnson_decoder.
// master = producer of code samples (consumer of status), slave = the decoder.
interface johnson_decoder_if #(
    parameter int N  = 4,
    parameter int IW = 3
);
    logic              sample_valid;
    logic [0:N-1]      code;
    logic [IW-1:0]     index;
    logic [2*N-1:0]    onehot;
    logic              valid_out;
    logic              locked;
    logic              step_err;
    logic [7:0]        err_count;

    modport master (
        output sample_valid, code,
        input  index, onehot, valid_out, locked, step_err, err_count
    );

    modport slave (
        input  sample_valid, code,
        output index, onehot, valid_out, locked, step_err, err_count
    );
endinterface

// File: rtl/johnson_decoder.sv
// johnson_decoder: decodes sampled N-bit Johnson words into a binary index and
// one-hot vector, tracks the legal successor sequence (IDLE/ACQ/LOCK) and
// counts sequence errors with an 8-bit saturating counter.
// Optional build macro JDEC_HOLD_EN: when defined, re-sampling the current
// code in ACQ/LOCK is a hold (stalled counter) rather than a non-successor.
//
// state | meaning
// IDLE  | no valid reference; next legal sample becomes the reference
// ACQ   | reference held, counting consecutive successor steps
// LOCK  | LOCK_LEN successors seen, every sample must be the successor
module johnson_decoder #(
    parameter int N        = 4,
    parameter int IW       = 3,
    parameter int LOCK_LEN = 2
) (
    input  logic            clk,
    input  logic            reset,
    johnson_decoder_if.slave bus
);
`ifdef JDEC_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCK} state_t;

    state_t          state_q;
    logic [IW-1:0]   index_q;
    logic [2*N-1:0]  onehot_q;
    logic            valid_q;
    logic            locked_q;
    logic            step_err_q;
    logic [7:0]      err_cnt_q;
    logic [3:0]      run_q;

    logic            code_legal;
    logic [IW-1:0]   code_idx;
    logic [IW-1:0]   succ_idx;
    logic            is_succ;
    logic            is_hold;
    logic            err_fire;

    function automatic logic [0:N-1] jcode(input int k);
        logic [0:N-1] c;
        for (int b = 0; b < N; b++)
            c[b] = (k <= N) ? (b < k) : (b >= k - N);
        return c;
    endfunction

    function automatic logic [2*N-1:0] oh_of(input logic [IW-1:0] i);
        logic [2*N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Decode the sampled word and classify it against the current reference.
    always_comb begin
        code_legal = 1'b0;
        code_idx   = '0;
        for (int k = 0; k < 2 * N; k++) begin
            if (bus.code == jcode(k)) begin
                code_legal = 1'b1;
                code_idx   = IW'(k);
            end
        end
        succ_idx = (index_q == IW'(2 * N - 1)) ? '0 : index_q + 1'b1;
        is_succ  = code_legal && (code_idx == succ_idx);
        is_hold  = HOLD_EN && code_legal && (code_idx == index_q);
        err_fire = bus.sample_valid &&
                   (!code_legal || (state_q == S_LOCK && !is_succ && !is_hold));
    end

    // Sequence tracker FSM with registered outputs and saturating error count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            index_q    <= '0;
            onehot_q   <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            step_err_q <= 1'b0;
            err_cnt_q  <= '0;
            run_q      <= '0;
        end else begin
            step_err_q <= err_fire;
            if (err_fire && err_cnt_q != 8'hFF)
                err_cnt_q <= err_cnt_q + 8'd1;
            if (bus.sample_valid) begin
                case (state_q)
                    S_IDLE: begin
                        if (code_legal) begin
                            index_q  <= code_idx;
                            onehot_q <= oh_of(code_idx);
                            valid_q  <= 1'b1;
                            run_q    <= '0;
                            state_q  <= S_ACQ;
                        end
                    end
                    S_ACQ: begin
                        if (!code_legal) begin
                            valid_q  <= 1'b0;
                            onehot_q <= '0;
                            run_q    <= '0;
                            state_q  <= S_IDLE;
                        end else if (is_hold) begin
                            state_q  <= S_ACQ;
                        end else if (is_succ) begin
                            index_q  <= code_idx;
                            onehot_q <= oh_of(code_idx);
                            run_q    <= run_q + 4'd1;
                            if (run_q + 4'd1 == 4'(LOCK_LEN)) begin
                                locked_q <= 1'b1;
                                state_q  <= S_LOCK;
                            end
                        end else begin
                            index_q  <= code_idx;
                            onehot_q <= oh_of(code_idx);
                            run_q    <= '0;
                        end
                    end
                    S_LOCK: begin
                        if (!code_legal) begin
                            valid_q  <= 1'b0;
                            onehot_q <= '0;
                            locked_q <= 1'b0;
                            run_q    <= '0;
                            state_q  <= S_IDLE;
                        end else if (is_hold) begin
                            state_q  <= S_LOCK;
                        end else if (is_succ) begin
                            index_q  <= code_idx;
                            onehot_q <= oh_of(code_idx);
                        end else begin
                            // Legal jump: keep the new index visible, drop lock.
                            index_q  <= code_idx;
                            onehot_q <= oh_of(code_idx);
                            locked_q <= 1'b0;
                            run_q    <= '0;
                            state_q  <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.index     = index_q;
    assign bus.onehot    = onehot_q;
    assign bus.valid_out = valid_q;
    assign bus.locked    = locked_q;
    assign bus.step_err  = step_err_q;
    assign bus.err_count = err_cnt_q;
endmodule

// File: tb/tb_johnson_decoder.sv
// tb_johnson_decoder: directed test-plan sequences plus randomized samples,
// checked by a scoreboard fed from an arithmetic reference model.
module tb_johnson_decoder;
    localparam int N        = 4;
    localparam int IW       = 3;
    localparam int LOCK_LEN = 2;
`ifdef JDEC_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] index;
        logic [7:0] onehot;
        logic       valid;
        logic       locked;
        logic       step_err;
        logic [7:0] err_count;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];
    exp_t last_exp;
    logic sv_q;

    // reference model state (0 idle, 1 acquiring, 2 locked)
    int m_state, m_run, m_idx, m_err;
    bit m_valid, m_locked;

    johnson_decoder_if #(.N(N), .IW(IW)) bus ();

    johnson_decoder #(.N(N), .IW(IW), .LOCK_LEN(LOCK_LEN)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [0:3] enc(input int k);
        int v;
        if (k <= N) v = ((1 << k) - 1) << (N - k);
        else        v = (1 << (2 * N - k)) - 1;
        return 4'(v);
    endfunction

    function automatic exp_t dut_out();
        exp_t a;
        a.index     = bus.index;
        a.onehot    = bus.onehot;
        a.valid     = bus.valid_out;
        a.locked    = bus.locked;
        a.step_err  = bus.step_err;
        a.err_count = bus.err_count;
        return a;
    endfunction

    task automatic check(input string name, input exp_t e);
        exp_t a;
        a = dut_out();
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s @%0t: got idx=%0d oh=%b v=%b lk=%b err=%b cnt=%0d, want idx=%0d oh=%b v=%b lk=%b err=%b cnt=%0d",
                     name, $time, a.index, a.onehot, a.valid, a.locked, a.step_err, a.err_count,
                     e.index, e.onehot, e.valid, e.locked, e.step_err, e.err_count);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_run = 0; m_idx = 0; m_err = 0;
        m_valid = 0; m_locked = 0;
    endtask

    task automatic model_sample(input logic [0:3] c, output exp_t e);
        int v, p, ki;
        bit legal, err, succ, hold;
        v = int'(c);
        p = $countones(c);
        legal = 0; ki = 0;
        if (v == (((1 << p) - 1) << (N - p))) begin
            legal = 1; ki = p;
        end else if (p > 0 && p < N && v == ((1 << p) - 1)) begin
            legal = 1; ki = 2 * N - p;
        end
        succ = legal && (ki == (m_idx + 1) % (2 * N));
        hold = HOLD && legal && (ki == m_idx);
        err  = 0;
        case (m_state)
            0: if (legal) begin
                   m_idx = ki; m_valid = 1; m_run = 0; m_state = 1;
               end else err = 1;
            1: if (!legal) begin
                   err = 1; m_valid = 0; m_run = 0; m_state = 0;
               end else if (hold) begin
               end else if (succ) begin
                   m_idx = ki; m_run++;
                   if (m_run == LOCK_LEN) begin m_state = 2; m_locked = 1; end
               end else begin
                   m_idx = ki; m_run = 0;
               end
            default: if (!legal) begin
                   err = 1; m_valid = 0; m_locked = 0; m_state = 0;
               end else if (hold) begin
               end else if (succ) begin
                   m_idx = ki;
               end else begin
                   err = 1; m_idx = ki; m_locked = 0; m_state = 0;
               end
        endcase
        if (err && m_err < 255) m_err++;
        e.index     = 3'(m_idx);
        e.onehot    = m_valid ? 8'(1 << m_idx) : 8'd0;
        e.valid     = m_valid;
        e.locked    = m_locked;
        e.step_err  = err;
        e.err_count = 8'(m_err);
    endtask

    task automatic drive(input logic sv, input logic [0:3] c);
        exp_t e;
        @(posedge clk);
        #1;
        bus.sample_valid = sv;
        bus.code         = c;
        if (sv) begin
            model_sample(c, e);
            q.push_back(e);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sv_q <= 1'b0;
        else        sv_q <= bus.sample_valid;
    end

    // Monitor: each sampled cycle pops one expectation; idle cycles must hold.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_exp = '0;
        end else if (sv_q) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_underflow @%0t: got empty queue, want an entry", $time);
            end else begin
                e = q.pop_front();
                check("sample", e);
                last_exp = e;
            end
        end else begin
            e = last_exp;
            e.step_err = 1'b0;
            check("idle_hold", e);
            last_exp = e;
        end
    end

    initial begin
        exp_t zero;
        int   r, r2, k;
        logic [0:3] c;
        zero = '0;
        model_reset();
        rst_n = 1'b0;
        bus.sample_valid = 1'b0;
        bus.code = '0;
        #3;
        check("reset_state", zero);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // full cycle with wrap 7 -> 0
        for (int i = 0; i <= 2 * N; i++) drive(1'b1, enc(i % (2 * N)));
        drive(1'b1, 4'b1010);                 // illegal while locked
        drive(1'b0, 4'b0000);
        // relock at 2, then skip to 4
        for (int i = 0; i <= 2; i++) drive(1'b1, enc(i));
        drive(1'b1, 4'b1111);
        drive(1'b0, 4'b0000);
        // lock at 3, then repeat twice
        for (int i = 1; i <= 3; i++) drive(1'b1, enc(i));
        drive(1'b1, 4'b1110);
        drive(1'b1, 4'b1110);
        drive(1'b0, 4'b0000);
        // error counter saturation
        for (int i = 0; i < 300; i++) drive(1'b1, 4'b0100);
        drive(1'b0, 4'b0000);

        // randomized mix of successors, repeats, legal jumps and arbitrary words
        for (int i = 0; i < 1500; i++) begin
            r  = $urandom_range(0, 9);
            r2 = $urandom_range(0, 5);
            case (r2)
                0, 1, 2: k = (m_idx + 1) % (2 * N);
                3:       k = m_idx;
                default: k = $urandom_range(0, 2 * N - 1);
            endcase
            c = (r2 == 5) ? 4'($urandom_range(0, 15)) : enc(k);
            drive(r != 0, c);
        end

        // async reset while locked at index 5
        drive(1'b0, 4'b0000);
        for (int i = 0; i <= 5; i++) drive(1'b1, enc(i));
        drive(1'b0, 4'b0000);
        drive(1'b0, 4'b0000);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", zero);
        q.delete();
        model_reset();
        #10;
        rst_n = 1'b1;
        drive(1'b1, 4'b0011);
        drive(1'b0, 4'b0000);
        drive(1'b0, 4'b0000);
        @(posedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/johnson_decoder.md
# johnson_decoder

Receive-side companion to the 4-bit Johnson (twisted-ring) counter: samples a Johnson code word, converts it to a binary state index and a one-hot vector, and checks that successive samples follow the legal Johnson sequence. It provides lock and error status and a saturating error count. It sits downstream of any Johnson counter whose output crosses into logic that needs a binary count or a sequence-integrity check.

## Interface
- N, default 4: Johnson code width; the sequence has 2N states.
- IW, default 3: index width, equal to clog2(2N).
- LOCK_LEN, default 2: number of consecutive legal successor steps required to declare lock (1..15).
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. Low clears all state immediately. Release is sampled on clk.
- sample_valid  input  1  code is sampled on this cycle.
- code  input  [0:N-1]  Johnson word; bit 0 is the shift-in end.
- index  output  [IW-1:0]  decoded state index of the last legal sample.
- onehot  output  [2N-1:0]  onehot[index] = 1 when valid_out is 1.
- valid_out  output  1  index and onehot reflect a legal sample.
- locked  output  1  the sequence is being tracked.
- step_err  output  1  single-cycle pulse on an illegal code or an illegal transition.
- err_count  output  8  saturating count of step_err pulses.

## Operation
- Legal code for index k, 0 ≤ k ≤ N: code[0..k-1] = 1, all other bits = 0. Examples: 0→0000, 1→1000, 4→1111.
- Legal code for index k, N < k < 2N: code[0..k-N-1] = 0, all other bits = 1. Examples: 5→0111, 7→0001.
- There are 2N legal codes. Every other pattern is illegal; for N=4 these are 8 of the 16 patterns, e.g. 1010 and 0100.
- Successor of index k is (k+1) mod 2N, so index 7 wraps to 0.
- The FSM has three states: IDLE, ACQ, LOCK.
  - IDLE: reset state. A legal sample loads index, sets valid_out, clears the run counter, and moves to ACQ. An illegal sample pulses step_err and stays in IDLE.
  - ACQ: a legal successor increments the run counter. When the run counter reaches LOCK_LEN, move to LOCK.
  - ACQ: a legal non-successor reloads index, restarts the run counter at 0, does not pulse step_err, and stays in ACQ.
  - ACQ: an illegal code pulses step_err, clears valid_out, and moves to IDLE.
  - LOCK: a legal successor updates index.
  - LOCK: an illegal code, or a legal code that is not the successor, pulses step_err, clears locked, and moves to IDLE. valid_out clears only when the code is illegal; otherwise index loads the new value and valid_out stays 1.
- Repeat samples, i.e. the same legal code as the current index: behaviour depends on the configuration macro below.
- sample_valid = 0: all state holds and step_err = 0.
- err_count increments on each step_err pulse and saturates at 255. Only reset clears it.

## Timing
- All outputs are registered. Response appears one cycle after the clk edge that samples sample_valid = 1.
- step_err is high for exactly one cycle for each offending sample, including back-to-back offending samples.
- locked rises in the cycle after the LOCK_LEN-th consecutive successor is sampled.
- Reset values: index = 0, onehot = 0, valid_out = 0, locked = 0, step_err = 0, err_count = 0, FSM = IDLE, run counter = 0.
- Reset asserted mid-sequence clears everything asynchronously. The first sample after release is treated as from IDLE.
- A wrap from index 2N-1 to index 0 counts as a successor step, not an error.

## Configuration
- JDEC_HOLD_EN, defined: a repeated legal code is a hold. Index is unchanged, there is no step_err, the run counter is unchanged, and the FSM state is unchanged. This supports a stalled counter sampled every cycle.
- JDEC_HOLD_EN, undefined: a repeated code is a non-successor. In ACQ it restarts the run counter. In LOCK it pulses step_err and moves to IDLE.

## Test plan
- Reset, then feed 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000, one per cycle, with LOCK_LEN=2. Required: index follows 0..7,0; locked = 1 one cycle after 1100 is sampled; step_err never pulses; wrap 7→0 is clean.
- While locked, feed 1010. Required: one-cycle step_err; valid_out = 0; locked = 0; err_count = 1; FSM in IDLE.
- While locked at index 2 (1100), feed 1111 (skip). Required: step_err pulse; index = 4; valid_out = 1; locked = 0.
- Locked at 1110, feed 1110 twice. With JDEC_HOLD_EN: index stays 3, locked stays 1, no error. Without it: step_err pulse on the first repeat and locked = 0.
- Feed 300 illegal samples of 0100. Required: err_count saturates at 255 with no wrap to 0; step_err pulses each cycle.
- Assert reset mid-stream while locked at index 5. Required: all outputs 0 immediately without a clock edge; after release, 0011 is accepted from IDLE with index = 6 and locked = 0.
